latch_bank: RTL
===============

Name: latch_bank

Overview:
- Parametrised, clocked successor to the single-bit-vector enable latch.
- Holds NUM_CH independent WIDTH-bit channels, each captured on its own enable.
- Each channel runs in one of two modes: FOLLOW (last-write-wins) or STICKY (first-write-wins until cleared).
- Adds per-channel valid, overrun detection, a saturating age counter, and a global output freeze for coherent multi-channel snapshots.
- Sits between status/event producers and software-visible or debug capture logic.

Parameters:
- WIDTH, 8, data bits per channel (>=1).
- NUM_CH, 4, number of channels (>=1).
- AGE_W, 8, width of the per-channel age counter (>=1).

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- wr_en  in  NUM_CH  per-channel capture enable.
- wr_data  in  NUM_CH*WIDTH  per-channel data; channel i occupies bits [i*WIDTH +: WIDTH].
- mode  in  NUM_CH  per-channel mode: 0 = FOLLOW, 1 = STICKY. Sampled every cycle.
- clr  in  NUM_CH  per-channel synchronous clear.
- freeze  in  1  while high, the output view is held constant.
- out_data  out  NUM_CH*WIDTH  visible data, same packing as wr_data.
- out_valid  out  NUM_CH  channel holds captured data.
- overrun  out  NUM_CH  sticky flag: a STICKY channel received wr_en while already HELD.
- age  out  NUM_CH*AGE_W  cycles since last capture, saturating.

Behaviour:
- Reset (async assert, sync-to-clk deassert assumed upstream): every channel goes to EMPTY. All of out_data, out_valid, overrun and age are 0. Internal storage and the output shadow are also 0. Reset mid-operation discards all state immediately.
- Per-channel FSM, states EMPTY and HELD:
  - EMPTY, wr_en=1 → HELD. data <= wr_data, age <= 0.
  - HELD, FOLLOW, wr_en=1 → HELD. data <= wr_data, age <= 0.
  - HELD, STICKY, wr_en=1 → HELD. Data unchanged, overrun <= 1, age keeps counting.
  - HELD, wr_en=0 → HELD. age <= min(age+1, 2^AGE_W-1).
  - EMPTY, wr_en=0 → EMPTY. age holds at 0.
- clr priority:
  - clr=1, wr_en=0 → EMPTY. data <= 0, age <= 0, overrun <= 0.
  - clr=1 and wr_en=1 in the same cycle: clear is applied first, then the write. Result is HELD with the new data, age=0, overrun=0, in either mode.
- Mode change while HELD: takes effect on the next wr_en. No data change.
- Latency: a capture at edge N is visible on out_data/out_valid after edge N (registered, 1 cycle from wr_en sampling). No combinational path from any input to any output.
- Freeze:
  - Outputs come from a shadow register set. While freeze=0, the shadow copies the internal next state every cycle, giving the 1-cycle latency above.
  - While freeze=1, all of out_data, out_valid, overrun and age hold the values present at the edge where freeze was first sampled high.
  - Internal state keeps updating during freeze: captures, overrun and age all continue.
  - On the first edge with freeze=0, the shadow loads the current internal state. Any events during the freeze become visible in one step.
- Age saturates at all-ones and never wraps. age=0 for EMPTY channels.
- Channels are fully independent. Simultaneous events on different channels do not interact.
- WIDTH=1 and NUM_CH=1 must elaborate and behave identically per channel.

Decomposition:
- Package latch_bank_pkg holds:
  - state enum {ST_EMPTY, ST_HELD};
  - mode constants MODE_FOLLOW = 1'b0, MODE_STICKY = 1'b1;
  - a function age_inc(age, AGE_W) with saturation.
- One natural sub-module, latch_bank_ch: the single-channel FSM, data register, overrun and age. It is instantiated NUM_CH times via generate.
- The top level owns the freeze shadow registers and the bus packing.

Test Plan:
- Reset then FOLLOW ch0: wr_en[0]=1, data 0x11, then 0x22 next cycle → out_data ch0 = 0x11, then 0x22, one cycle after each write. out_valid[0]=1. age[0]=0 each time, then counts 1, 2, 3.
- STICKY ch1: write 0xA5, then write 0x5A → ch1 stays 0xA5 and overrun[1] rises to 1. clr[1] → out_valid[1]=0, data 0, overrun[1]=0.
- Same-cycle clr[2] and wr_en[2] with 0x3C, ch2 previously HELD STICKY with overrun=1 → ch2 = 0x3C, valid=1, overrun=0, age=0.
- AGE_W=2, hold ch3 for 6 cycles → age[3] goes 0, 1, 2, 3, 3, 3 (no wrap).
- freeze=1 for 4 cycles while ch0 is rewritten with 0x77 → outputs stay at pre-freeze values. The first cycle after release shows 0x77 and age counted from the write.
- Assert rst_n=0 asynchronously mid-cycle with all channels HELD → all outputs 0 immediately, before the next clk edge. After release, first writes behave as from EMPTY.

Source files
------------

// File: rtl/latch_bank_pkg.sv
// latch_bank_pkg: shared types, mode encodings and the saturating age helper
// used by the latch_bank top level and its per-channel sub-module.
package latch_bank_pkg;

  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_HELD  = 1'b1
  } ch_state_e;

  localparam logic MODE_FOLLOW = 1'b0;
  localparam logic MODE_STICKY = 1'b1;

  // Widest age counter the helper supports; channel ages are zero-extended
  // into this width before incrementing.
  localparam int AGE_MAX_W = 32;

  // Increment age by one, saturating at the all-ones value of an age_w-bit
  // counter instead of wrapping.
  function automatic logic [AGE_MAX_W-1:0] age_inc(
    input logic [AGE_MAX_W-1:0] age,
    input int                   age_w
  );
    logic [AGE_MAX_W-1:0] sat;
    if (age_w >= AGE_MAX_W) sat = '1;
    else                    sat = (AGE_MAX_W'(1) << age_w) - AGE_MAX_W'(1);
    return (age >= sat) ? sat : age + AGE_MAX_W'(1);
  endfunction

endpackage

// File: rtl/latch_bank_ch.sv
// latch_bank_ch: one capture channel. Two-state FSM (EMPTY/HELD), data
// register, sticky overrun flag and saturating age counter.
// Ports:
//   clk, rst_n              clock, async active-low reset
//   wr_en, wr_data          capture enable and data for this channel
//   mode                    0 = FOLLOW (last write wins), 1 = STICKY
//   clr                     synchronous clear, applied before a same-cycle write
//   nxt_data/valid/overrun/age
//                           next-state view; the top registers it into the
//                           output shadow so no input reaches an output
//                           combinationally
module latch_bank_ch
  import latch_bank_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int AGE_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             mode,
  input  logic             clr,
  output logic [WIDTH-1:0] nxt_data,
  output logic             nxt_valid,
  output logic             nxt_overrun,
  output logic [AGE_W-1:0] nxt_age
);

  ch_state_e        state_q, state_d, st_eff;
  logic [WIDTH-1:0] data_q, data_d;
  logic             ovr_q, ovr_d;
  logic [AGE_W-1:0] age_q, age_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_EMPTY;
      data_q  <= '0;
      ovr_q   <= 1'b0;
      age_q   <= '0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      ovr_q   <= ovr_d;
      age_q   <= age_d;
    end
  end

  // Clear is folded in first: the FSM then sees an EMPTY channel, so a
  // same-cycle write always lands as a fresh capture regardless of mode.
  always_comb begin
    st_eff  = clr ? ST_EMPTY : state_q;
    state_d = st_eff;
    data_d  = clr ? '0 : data_q;
    ovr_d   = clr ? 1'b0 : ovr_q;
    age_d   = '0;
    case (st_eff)
      ST_EMPTY: begin
        if (wr_en) begin
          state_d = ST_HELD;
          data_d  = wr_data;
        end
      end
      ST_HELD: begin
        if (wr_en && mode == MODE_FOLLOW) begin
          data_d = wr_data;
        end else begin
          // STICKY write to a held channel is refused but flagged; the
          // captured value keeps ageing.
          if (wr_en) ovr_d = 1'b1;
          age_d = AGE_W'(age_inc(AGE_MAX_W'(age_q), AGE_W));
        end
      end
    endcase
  end

  assign nxt_data    = data_d;
  assign nxt_valid   = (state_d == ST_HELD);
  assign nxt_overrun = ovr_d;
  assign nxt_age     = age_d;

endmodule

// File: rtl/latch_bank.sv
// latch_bank: NUM_CH independent WIDTH-bit capture channels with FOLLOW /
// STICKY modes, per-channel valid, overrun and saturating age, plus a global
// freeze that holds the whole output view for a coherent snapshot.
// Ports:
//   clk, rst_n    clock, async active-low reset
//   wr_en         per-channel capture enable
//   wr_data       per-channel data, channel i at [i*WIDTH +: WIDTH]
//   mode          per-channel mode (0 FOLLOW, 1 STICKY)
//   clr           per-channel synchronous clear
//   freeze        hold all outputs while high
//   out_data      visible data, same packing as wr_data
//   out_valid     channel holds captured data
//   overrun       sticky write refused on a held channel
//   age           cycles since last capture, channel i at [i*AGE_W +: AGE_W]
module latch_bank
  import latch_bank_pkg::*;
#(
  parameter int WIDTH  = 8,
  parameter int NUM_CH = 4,
  parameter int AGE_W  = 8
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [NUM_CH-1:0]       wr_en,
  input  logic [NUM_CH*WIDTH-1:0] wr_data,
  input  logic [NUM_CH-1:0]       mode,
  input  logic [NUM_CH-1:0]       clr,
  input  logic                    freeze,
  output logic [NUM_CH*WIDTH-1:0] out_data,
  output logic [NUM_CH-1:0]       out_valid,
  output logic [NUM_CH-1:0]       overrun,
  output logic [NUM_CH*AGE_W-1:0] age
);

  logic [NUM_CH-1:0][WIDTH-1:0] nxt_data, sh_data;
  logic [NUM_CH-1:0][AGE_W-1:0] nxt_age, sh_age;
  logic [NUM_CH-1:0]            nxt_valid, sh_valid;
  logic [NUM_CH-1:0]            nxt_ovr, sh_ovr;

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    latch_bank_ch #(
      .WIDTH (WIDTH),
      .AGE_W (AGE_W)
    ) u_ch (
      .clk         (clk),
      .rst_n       (rst_n),
      .wr_en       (wr_en[i]),
      .wr_data     (wr_data[i*WIDTH +: WIDTH]),
      .mode        (mode[i]),
      .clr         (clr[i]),
      .nxt_data    (nxt_data[i]),
      .nxt_valid   (nxt_valid[i]),
      .nxt_overrun (nxt_ovr[i]),
      .nxt_age     (nxt_age[i])
    );
  end

  // Shadow tracks the channels' next state when unfrozen (one-cycle
  // latency from wr_en) and simply holds while frozen; the first unfrozen
  // edge catches up with everything that happened in between.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sh_data  <= '0;
      sh_valid <= '0;
      sh_ovr   <= '0;
      sh_age   <= '0;
    end else if (!freeze) begin
      sh_data  <= nxt_data;
      sh_valid <= nxt_valid;
      sh_ovr   <= nxt_ovr;
      sh_age   <= nxt_age;
    end
  end

  assign out_data  = sh_data;
  assign out_valid = sh_valid;
  assign overrun   = sh_ovr;
  assign age       = sh_age;

endmodule
